// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART instruction loader: handshake bytes and
// the session state encoding.
package uart_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hAA;
  localparam logic [7:0] LOADER_NAK  = 8'h55;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    ACK  = 3'd5,
    FIN  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/uart_loader_word_asm.sv
// Big-endian byte-to-word assembler: first byte lands in bits [31:24].
// word_valid is high in the cycle the fourth byte is presented, and word_out
// already contains that byte, so the caller can register the word directly.
module loader_word_asm (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [31:0] shift_reg;
  logic [1:0]  cnt_reg;

  // Shift each accepted byte in from the right and count bytes modulo four.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      shift_reg <= 32'd0;
      cnt_reg   <= 2'd0;
    end else if (byte_valid) begin
      shift_reg <= {shift_reg[23:0], byte_in};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word_valid = byte_valid && (cnt_reg == 2'd3);
  assign word_out   = {shift_reg[23:0], byte_in};

endmodule

// File: rtl/uart_loader.sv
// UART instruction loader: sends a sync byte, receives a 32-bit word count
// and that many big-endian words, writes them to instruction memory and
// answers with ACK (0xAA) or NAK (0x55).
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing XOR
// checksum byte that is verified before the answer is sent.
module uart_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import uart_loader_pkg::*;

  // Largest accepted word count: exactly fills the memory.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  loader_state_t     state_reg, state_next;
  logic [31:0]       rem_reg, rem_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              imem_we_reg, imem_we_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic        byte_valid;
  logic        asm_clr;
  logic        word_valid;
  logic [31:0] word_out;

  // Bytes are only meaningful while collecting the count or the payload.
  assign byte_valid = rx_ready && ((state_reg == LEN) || (state_reg == DATA));
  // Holding the assembler clear in IDLE guarantees a fresh byte phase per session.
  assign asm_clr    = (state_reg == IDLE);

  loader_word_asm u_word_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (asm_clr),
    .byte_valid (byte_valid),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  // State and registered outputs; reset aborts any session in progress.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      rem_reg        <= 32'd0;
      idx_reg        <= '0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= 8'd0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= 32'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg       <= 8'd0;
`endif
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      idx_reg        <= idx_next;
      tx_start_reg   <= tx_start_next;
      tx_data_reg    <= tx_data_next;
      imem_we_reg    <= imem_we_next;
      imem_addr_reg  <= imem_addr_next;
      imem_wdata_reg <= imem_wdata_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
`ifdef LOADER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  // Next-state and next-output logic for the load session.
  always_comb begin
    state_next      = state_reg;
    rem_next        = rem_reg;
    idx_next        = idx_reg;
    tx_start_next   = 1'b0;
    tx_data_next    = tx_data_reg;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr_reg;
    imem_wdata_next = imem_wdata_reg;
    done_next       = done_reg;
    err_next        = err_reg;
`ifdef LOADER_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SYNC;
          done_next  = 1'b0;
          err_next   = 1'b0;
          idx_next   = '0;
          rem_next   = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = 8'd0;
`endif
        end
      end
      SYNC: begin
        if (!tx_busy && !tx_start_reg) begin
          tx_start_next = 1'b1;
          tx_data_next  = LOADER_SYNC;
          state_next    = LEN;
        end
      end
      LEN: begin
        if (word_valid) begin
          rem_next = word_out;
          if ({1'b0, word_out} > MAX_WORDS) begin
            // Oversized image: refuse it without touching memory.
            err_next   = 1'b1;
            state_next = ACK;
          end else if (word_out != 32'd0) begin
            state_next = DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = ACK;
`endif
          end
        end
      end
      DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_valid) begin
          csum_next = csum_reg ^ rx_data;
        end
`endif
        if (word_valid) begin
          imem_we_next    = 1'b1;
          imem_addr_next  = idx_reg;
          imem_wdata_next = word_out;
          rem_next        = rem_reg - 32'd1;
          if (rem_reg == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = ACK;
`endif
          end else begin
            // Only advance when another word follows, so a full memory never wraps.
            idx_next = idx_reg + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (rx_ready) begin
          if (rx_data != csum_reg) begin
            err_next = 1'b1;
          end
          state_next = ACK;
        end
      end
`endif
      ACK: begin
        if (!tx_busy && !tx_start_reg) begin
          tx_start_next = 1'b1;
          tx_data_next  = err_reg ? LOADER_NAK : LOADER_SYNC;
          done_next     = !err_reg;
          state_next    = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE) && (state_next != FIN);
  end

  assign tx_start   = tx_start_reg;
  assign tx_data    = tx_data_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of instruction memory.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse beginning a load session.
REQ-005 SHALL have port rx_ready  input  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port tx_start  output  1  one-cycle send strobe to UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte to send, held stable while tx_start high.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-011 SHALL have port imem_addr  output  ADDR_W  word address.
REQ-012 SHALL have port imem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have ports busy, done, err  output  1 each  session active / finished OK / finished with error.

Function
REQ-014 SHALL implement states IDLE, SYNC, LEN, DATA, CSUM, ACK, FIN.
REQ-015 IDLE: start -> SYNC, clearing done/err, word index and byte counter; rx_ready ignored.
REQ-016 SYNC: when tx_busy low, pulse tx_start with tx_data=0xAA and enter LEN; rx_ready ignored.
REQ-017 LEN: collect 4 bytes big-endian into 32-bit count N; after 4th byte -> DATA if N>0, else ACK (CSUM if checksum enabled).
REQ-018 N > 2**ADDR_W SHALL set err and enter ACK with NAK 0x55; no memory writes.
REQ-019 DATA: collect 4 bytes big-endian per word; the cycle after the 4th byte imem_we=1, imem_addr=word index, imem_wdata=word; index then increments.
REQ-020 After word N-1 -> CSUM if enabled, else ACK; index SHALL NOT wrap (bounded by REQ-018).
REQ-021 ACK: when tx_busy low, pulse tx_start with 0xAA (no error) or 0x55 (err), then FIN.
REQ-022 FIN: busy low, done=1 if no error, err held; -> IDLE next cycle, done/err held until next start.
REQ-023 busy SHALL be high in every state except IDLE and FIN.
REQ-024 start while busy SHALL be ignored.
REQ-025 tx_start SHALL never assert while tx_busy high nor on two consecutive cycles.
REQ-026 Each rx_ready strobe SHALL be consumed exactly once; rx_ready coinciding with imem_we SHALL be captured.

Reset
REQ-027 rstn low: state IDLE; tx_start, tx_data, imem_we, imem_addr, imem_wdata, busy, done, err all 0; counters 0.
REQ-028 Reset mid-session SHALL abort immediately; already-written words remain, no ACK sent.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: CSUM state consumes one byte; mismatch with XOR of all DATA bytes sets err (NAK sent).
REQ-030 Macro LOADER_CHECKSUM_EN undefined: CSUM state and XOR accumulator absent; DATA/LEN go directly to ACK.

Structure
REQ-031 Shared package constant SHALL hold LOADER_SYNC=8'hAA, LOADER_NAK=8'h55 and the loader state enum typedef.
REQ-032 Byte-to-word big-endian assembly SHALL be sub-module loader_word_asm (shift register plus 2-bit byte count, word_valid strobe).

Verification
REQ-033 start, N=2, bytes 00 00 00 02 | 24 01 00 05 | AC 01 00 00 -> 0xAA sent first; writes addr0=0x24010005, addr1=0xAC010000; 0xAA ack; done=1.
REQ-034 N=0 -> 0xAA sync, no imem_we, 0xAA ack, done=1.
REQ-035 ADDR_W=12, N=0x00001001 -> no writes, 0x55 sent, err=1, done=0.
REQ-036 tx_busy held high 100 cycles in SYNC -> tx_start waits until tx_busy low, then single pulse.
REQ-037 rstn low after 2 of 4 DATA bytes -> IDLE, no further writes; new start runs full session correctly.
REQ-038 LOADER_CHECKSUM_EN, one word 01 02 03 04 then checksum 0x05 -> 0x55 sent, err=1; checksum 0x04 -> 0xAA, done=1.
